// File: rtl/adapter_test_wrapper.sv
// SiTCP RBCP byte-wide register bridge to one 32-bit output GPIO word and one
// synchronized 32-bit input GPIO word, both big-endian within the word.
module adapter_test_wrapper #(
  parameter logic [31:0] WR_BASE = 32'd0,
  parameter logic [31:0] RD_BASE = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aux_reset_in,
  input  logic        rbcp_act,
  input  logic [31:0] rbcp_addr,
  input  logic        rbcp_we,
  input  logic [7:0]  rbcp_wd,
  input  logic        rbcp_re,
  output logic [7:0]  rbcp_rd,
  output logic        rbcp_ack,
  output logic [31:0] GPIO_0_tri_o,
  input  logic [31:0] GPIO_1_tri_i
);

  logic        int_rst;
  logic        accept;
  logic        do_write;
  logic        do_read;
  logic [31:0] wr_offset;
  logic [31:0] rd_offset;
  logic        wr_hit;
  logic        rd_hit;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;

  logic [31:0] gpio_out_q, gpio_out_d;
  logic [31:0] sync1_q, sync1_d;
  logic [31:0] sync2_q, sync2_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d;

  assign int_rst = rst | ~aux_reset_in;

  // Offsets wrap modulo 2^32, so "offset < 4" matches exactly four addresses
  // of the full 32-bit space and never aliases.
  assign wr_offset = rbcp_addr - WR_BASE;
  assign rd_offset = rbcp_addr - RD_BASE;
  assign wr_hit    = (wr_offset < 32'd4);
  assign rd_hit    = (rd_offset < 32'd4);
  assign wr_sel    = wr_offset[1:0];
  assign rd_sel    = rd_offset[1:0];

  assign accept   = rbcp_act & (rbcp_we | rbcp_re);
  assign do_write = accept & rbcp_we;
  assign do_read  = accept & rbcp_re & ~rbcp_we;

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      2'd0: b = word[31:24];
      2'd1: b = word[23:16];
      2'd2: b = word[15:8];
      2'd3: b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    sync1_d    = GPIO_1_tri_i;
    sync2_d    = sync1_q;
    gpio_out_d = gpio_out_q;
    ack_d      = accept;
    rd_d       = 8'h00;

    if (do_write && wr_hit) begin
      case (wr_sel)
        2'd0: gpio_out_d[31:24] = rbcp_wd;
        2'd1: gpio_out_d[23:16] = rbcp_wd;
        2'd2: gpio_out_d[15:8]  = rbcp_wd;
        2'd3: gpio_out_d[7:0]   = rbcp_wd;
        default: gpio_out_d = gpio_out_q;
      endcase
    end

    if (do_read) begin
      if (wr_hit)
        rd_d = pick_byte(gpio_out_q, wr_sel);
      else if (rd_hit)
        rd_d = pick_byte(sync2_q, rd_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (int_rst) begin
      gpio_out_q <= 32'h0;
      sync1_q    <= 32'h0;
      sync2_q    <= 32'h0;
      ack_q      <= 1'b0;
      rd_q       <= 8'h00;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
    end
  end

  assign GPIO_0_tri_o = gpio_out_q;
  assign rbcp_ack     = ack_q;
  assign rbcp_rd      = rd_q;

endmodule

// File: tb/tb_adapter_test_wrapper.sv
// Directed, table-driven bench for adapter_test_wrapper with a few hand-written
// multi-cycle sequences for synchronizer latency, back-to-back and reset cases.
module tb_adapter_test_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        aux_reset_in;
  logic        rbcp_act;
  logic [31:0] rbcp_addr;
  logic        rbcp_we;
  logic [7:0]  rbcp_wd;
  logic        rbcp_re;
  logic [7:0]  rbcp_rd;
  logic        rbcp_ack;
  logic [31:0] GPIO_0_tri_o;
  logic [31:0] GPIO_1_tri_i;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    logic        act;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic [31:0] gpioIn;
    logic        expAck;
    logic [7:0]  expRd;
    logic [31:0] expGpio;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  adapter_test_wrapper dut (
    .clk          (clk),
    .rst          (rst),
    .aux_reset_in (aux_reset_in),
    .rbcp_act     (rbcp_act),
    .rbcp_addr    (rbcp_addr),
    .rbcp_we      (rbcp_we),
    .rbcp_wd      (rbcp_wd),
    .rbcp_re      (rbcp_re),
    .rbcp_rd      (rbcp_rd),
    .rbcp_ack     (rbcp_ack),
    .GPIO_0_tri_o (GPIO_0_tri_o),
    .GPIO_1_tri_i (GPIO_1_tri_i)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic act, input logic we, input logic re,
                                 input logic [31:0] addr, input logic [7:0] wd,
                                 input logic [31:0] gpioIn, input logic expAck,
                                 input logic [7:0] expRd, input logic [31:0] expGpio);
    vec_t v;
    v.act = act; v.we = we; v.re = re; v.addr = addr; v.wd = wd;
    v.gpioIn = gpioIn; v.expAck = expAck; v.expRd = expRd; v.expGpio = expGpio;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One strobe cycle, then the ack cycle is checked, then the idle cycle after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    GPIO_1_tri_i = v.gpioIn;
    repeat (3) @(negedge clk);
    rbcp_act  = v.act;
    rbcp_we   = v.we;
    rbcp_re   = v.re;
    rbcp_addr = v.addr;
    rbcp_wd   = v.wd;
    @(posedge clk);
    #1;
    rbcp_we  = 1'b0;
    rbcp_re  = 1'b0;
    rbcp_act = 1'b1;
    checkOutput($sformatf("vec%0d_ack", idx), {31'b0, rbcp_ack}, {31'b0, v.expAck});
    checkOutput($sformatf("vec%0d_rd", idx), {24'b0, rbcp_rd}, {24'b0, v.expRd});
    checkOutput($sformatf("vec%0d_gpio", idx), GPIO_0_tri_o, v.expGpio);
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_ack_low", idx), {31'b0, rbcp_ack}, 32'd0);
    checkOutput($sformatf("vec%0d_rd_idle", idx), {24'b0, rbcp_rd}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mkVec(1, 0, 1, 32'd8,  8'h00, 32'h11223344, 1, 8'h11, 32'h0);
    vecs[1]  = mkVec(1, 0, 1, 32'd9,  8'h00, 32'h11223344, 1, 8'h22, 32'h0);
    vecs[2]  = mkVec(1, 0, 1, 32'd10, 8'h00, 32'h11223344, 1, 8'h33, 32'h0);
    vecs[3]  = mkVec(1, 0, 1, 32'd11, 8'h00, 32'h11223344, 1, 8'h44, 32'h0);
    vecs[4]  = mkVec(1, 0, 1, 32'd8,  8'h00, 32'h55667788, 1, 8'h55, 32'h0);
    vecs[5]  = mkVec(1, 0, 1, 32'd9,  8'h00, 32'h55667788, 1, 8'h66, 32'h0);
    vecs[6]  = mkVec(1, 0, 1, 32'd10, 8'h00, 32'h55667788, 1, 8'h77, 32'h0);
    vecs[7]  = mkVec(1, 0, 1, 32'd11, 8'h00, 32'h55667788, 1, 8'h88, 32'h0);
    vecs[8]  = mkVec(1, 1, 0, 32'd0,  8'h11, 32'h55667788, 1, 8'h00, 32'h11000000);
    vecs[9]  = mkVec(1, 1, 0, 32'd1,  8'h22, 32'h55667788, 1, 8'h00, 32'h11220000);
    vecs[10] = mkVec(1, 1, 0, 32'd2,  8'h33, 32'h55667788, 1, 8'h00, 32'h11223300);
    vecs[11] = mkVec(1, 1, 0, 32'd3,  8'h44, 32'h55667788, 1, 8'h00, 32'h11223344);
    vecs[12] = mkVec(1, 1, 0, 32'd4,  8'hAA, 32'h55667788, 1, 8'h00, 32'h11223344);
    vecs[13] = mkVec(1, 1, 0, 32'd0,  8'h55, 32'h55667788, 1, 8'h00, 32'h55223344);
    vecs[14] = mkVec(1, 1, 0, 32'd1,  8'h66, 32'h55667788, 1, 8'h00, 32'h55663344);
    vecs[15] = mkVec(1, 1, 0, 32'd2,  8'h77, 32'h55667788, 1, 8'h00, 32'h55667744);
    vecs[16] = mkVec(1, 1, 0, 32'd3,  8'h88, 32'h55667788, 1, 8'h00, 32'h55667788);
    vecs[17] = mkVec(1, 0, 1, 32'd2,  8'h00, 32'h55667788, 1, 8'h77, 32'h55667788);
    vecs[18] = mkVec(1, 0, 1, 32'd0,  8'h00, 32'h55667788, 1, 8'h55, 32'h55667788);
    vecs[19] = mkVec(1, 0, 1, 32'd12, 8'h00, 32'h55667788, 1, 8'h00, 32'h55667788);
    vecs[20] = mkVec(1, 1, 0, 32'd9,  8'hFF, 32'h55667788, 1, 8'h00, 32'h55667788);
    vecs[21] = mkVec(0, 1, 0, 32'd0,  8'h00, 32'h55667788, 0, 8'h00, 32'h55667788);
    vecs[22] = mkVec(1, 1, 1, 32'd1,  8'hC3, 32'h55667788, 1, 8'h00, 32'h55C37788);
    vecs[23] = mkVec(1, 0, 1, 32'h00000108, 8'h00, 32'h55667788, 1, 8'h00, 32'h55C37788);
    vecs[24] = mkVec(1, 1, 0, 32'h10000000, 8'hEE, 32'h55667788, 1, 8'h00, 32'h55C37788);
    vecs[25] = mkVec(0, 0, 1, 32'd8,  8'h00, 32'h55667788, 0, 8'h00, 32'h55C37788);

    rst          = 1'b1;
    aux_reset_in = 1'b1;
    rbcp_act     = 1'b1;
    rbcp_addr    = 32'h0;
    rbcp_we      = 1'b0;
    rbcp_wd      = 8'h00;
    rbcp_re      = 1'b0;
    GPIO_1_tri_i = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_gpio", GPIO_0_tri_o, 32'h0);
    checkOutput("reset_ack", {31'b0, rbcp_ack}, 32'd0);
    checkOutput("reset_rd", {24'b0, rbcp_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      applyStimulus(vecs[i], i);

    // Back-to-back reads across an input change: the first two still see the old word.
    @(negedge clk);
    GPIO_1_tri_i = 32'hA1B2C3D4;
    rbcp_addr    = 32'd8;
    rbcp_re      = 1'b1;
    @(posedge clk); #1;
    checkOutput("b2b0_ack", {31'b0, rbcp_ack}, 32'd1);
    checkOutput("b2b0_rd", {24'b0, rbcp_rd}, 32'h55);
    @(posedge clk); #1;
    checkOutput("b2b1_ack", {31'b0, rbcp_ack}, 32'd1);
    checkOutput("b2b1_rd", {24'b0, rbcp_rd}, 32'h55);
    @(posedge clk); #1;
    rbcp_re = 1'b0;
    checkOutput("b2b2_ack", {31'b0, rbcp_ack}, 32'd1);
    checkOutput("b2b2_rd", {24'b0, rbcp_rd}, 32'hA1);
    @(posedge clk); #1;
    checkOutput("b2b_end_ack", {31'b0, rbcp_ack}, 32'd0);
    checkOutput("b2b_end_rd", {24'b0, rbcp_rd}, 32'd0);

    // Back-to-back writes to bytes 3 and 0.
    @(negedge clk);
    rbcp_we = 1'b1; rbcp_addr = 32'd3; rbcp_wd = 8'h5A;
    @(negedge clk);
    checkOutput("bw0_ack", {31'b0, rbcp_ack}, 32'd1);
    checkOutput("bw0_gpio", GPIO_0_tri_o, 32'h55C3775A);
    rbcp_addr = 32'd0; rbcp_wd = 8'hE7;
    @(negedge clk);
    rbcp_we = 1'b0;
    checkOutput("bw1_ack", {31'b0, rbcp_ack}, 32'd1);
    checkOutput("bw1_gpio", GPIO_0_tri_o, 32'hE7C3775A);
    @(negedge clk);
    checkOutput("bw_end_ack", {31'b0, rbcp_ack}, 32'd0);

    // Strobe coinciding with reset is dropped and its ack never appears.
    @(negedge clk);
    rst = 1'b1; rbcp_we = 1'b1; rbcp_addr = 32'd3; rbcp_wd = 8'h99;
    @(negedge clk);
    rst = 1'b0; rbcp_we = 1'b0;
    checkOutput("rst_strobe_ack", {31'b0, rbcp_ack}, 32'd0);
    checkOutput("rst_strobe_gpio", GPIO_0_tri_o, 32'h0);

    // Auxiliary reset alone clears the output word.
    @(negedge clk);
    rbcp_we = 1'b1; rbcp_addr = 32'd2; rbcp_wd = 8'h3C;
    @(negedge clk);
    rbcp_we = 1'b0;
    checkOutput("pre_aux_gpio", GPIO_0_tri_o, 32'h00003C00);
    aux_reset_in = 1'b0;
    @(negedge clk);
    aux_reset_in = 1'b1;
    checkOutput("aux_reset_gpio", GPIO_0_tri_o, 32'h0);
    checkOutput("aux_reset_ack", {31'b0, rbcp_ack}, 32'd0);

    // Read of an input byte right after aux reset: synchronizer was cleared.
    rbcp_re = 1'b1; rbcp_addr = 32'd11;
    @(negedge clk);
    rbcp_re = 1'b0;
    checkOutput("post_aux_rd", {24'b0, rbcp_rd}, 32'd0);
    checkOutput("post_aux_ack", {31'b0, rbcp_ack}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/adapter_test_wrapper.md
Name: adapter_test_wrapper

Overview:
- Bridges the SiTCP RBCP register bus to two 32-bit GPIO ports.
- RBCP byte writes at addresses 0..3 assemble the 32-bit output word GPIO_0_tri_o.
- RBCP byte reads at addresses 8..11 return bytes of the synchronized 32-bit input word GPIO_1_tri_i.
- Sits between the SiTCP core's RBCP interface and fabric logic driven by or observing the GPIO words.

Parameters:
- WR_BASE, 32'd0, base address of the 4-byte output register; bytes at WR_BASE..WR_BASE+3.
- RD_BASE, 32'd8, base address of the 4-byte input register; bytes at RD_BASE..RD_BASE+3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- aux_reset_in  in  1  auxiliary reset, synchronous, active-low; 1 = inactive. Combined with rst: internal reset = rst | ~aux_reset_in.
- rbcp_act  in  1  RBCP session active; strobes are ignored while 0.
- rbcp_addr  in  32  RBCP byte address; sampled with the strobe.
- rbcp_we  in  1  write strobe, one-cycle pulse.
- rbcp_wd  in  8  write data; sampled with rbcp_we.
- rbcp_re  in  1  read strobe, one-cycle pulse.
- rbcp_rd  out  8  read data; valid in the cycle rbcp_ack is high.
- rbcp_ack  out  1  one-cycle acknowledge.
- GPIO_0_tri_o  out  32  output word, registered.
- GPIO_1_tri_i  in  32  input word, asynchronous to the bus transaction.

Behaviour:
- Reset (internal reset high at a clk edge):
  - GPIO_0_tri_o = 0, rbcp_ack = 0, rbcp_rd = 0.
  - Input synchronizer cleared to 0.
  - A strobe arriving during reset is dropped and not acked.
- Byte order is big-endian:
  - Offset 0 maps to bits [31:24], offset 1 to [23:16], offset 2 to [15:8], offset 3 to [7:0].
  - Applies to both the output and the input register.
- Input path:
  - GPIO_1_tri_i passes through a 2-flop synchronizer; reads return the synchronized value.
  - Latency from an input change to being readable: 2 clk.
- Acceptance: a strobe is accepted in cycle N when rbcp_act=1 and (rbcp_we | rbcp_re)=1.
- Write, accepted in cycle N:
  - If rbcp_addr is in WR_BASE..WR_BASE+3, the addressed byte of GPIO_0_tri_o takes rbcp_wd at the edge ending cycle N. The output is visible in cycle N+1.
  - Other bytes are unchanged.
  - Writes to any other address (including RD_BASE range and addr 4) change nothing.
- Read, accepted in cycle N:
  - rbcp_rd is registered from the decoded address and valid in cycle N+1.
  - WR_BASE range returns the current GPIO_0_tri_o byte (readback).
  - RD_BASE range returns the synchronized GPIO_1 byte.
  - Any other address returns 8'h00.
- Ack:
  - rbcp_ack = 1 for exactly one cycle, N+1, for every accepted strobe, mapped or not.
  - rbcp_ack is 0 in all other cycles.
  - rbcp_rd returns to 8'h00 when ack is low.
- Simultaneous we and re in one cycle: treated as a write only; one ack; rbcp_rd = 8'h00.
- Back-to-back strobes in consecutive cycles are each accepted and acked in order; no stall or busy state.
- Address compare uses the full 32 bits; no aliasing.
- rbcp_act = 0: strobes are ignored (no ack, no write). Registers hold their values.
- Reset asserted between strobe and ack: the pending ack is cancelled.

Test Plan:
- Reset: hold rst=1 with aux_reset_in=1 -> GPIO_0_tri_o=0, rbcp_ack=0. Then set aux_reset_in=0 with rst=0 -> same reset state.
- Read path:
  - GPIO_1_tri_i=32'h11223344, wait at least 3 clk, read addrs 8,9,10,11 -> rbcp_rd 8'h11, 8'h22, 8'h33, 8'h44, each with a one-cycle ack one clk after re.
  - Then GPIO_1_tri_i=32'h55667788 -> 8'h55, 8'h66, 8'h77, 8'h88.
- Write path:
  - Write 0x11, 0x22, 0x33, 0x44 to addrs 0..3 -> GPIO_0_tri_o=32'h11223344.
  - Write 0xAA to addr 4 -> acked, GPIO_0_tri_o unchanged.
  - Write 0x55, 0x66, 0x77, 0x88 to addrs 0..3 -> 32'h55667788.
- Readback and unmapped:
  - Read addr 2 after GPIO_0=32'h55667788 -> 8'h77.
  - Read addr 12 -> 8'h00 with ack.
  - Write addr 9 -> GPIO unchanged, acked.
- Gating and collision:
  - rbcp_act=0 with we to addr 0 -> no ack, no change.
  - we and re together at addr 1, wd=0xC3 -> single ack, byte [23:16]=0xC3, rbcp_rd=0.
